// File: rtl/isp_seq_divider_pkg.sv
// Shared definitions for the sequential fixed-point divider.
package isp_seq_divider_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of restoring steps: one per bit of the scaled dividend.
    function automatic int unsigned n_iter(input int unsigned width, input int unsigned shift);
        return width + shift;
    endfunction

    // Width of a down-counter that must hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/isp_seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when there is no borrow.
module isp_seq_divider_div_step #(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             n_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   b;
    logic [WIDTH-1:0] diff;
    logic             cout;

    assign t = {r_in, n_msb};
    assign b = ~{1'b0, divisor};

    // Ripple-carry t + ~divisor + 1; carry out set means t >= divisor.
    // Only the low WIDTH sum bits are kept since an accepted difference
    // is always below the divisor.
    always_comb begin
        logic c;
        c    = 1'b1;
        diff = '0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            if (i < int'(WIDTH)) begin
                diff[i] = t[i] ^ b[i] ^ c;
            end
            c = (t[i] & b[i]) | (c & (t[i] ^ b[i]));
        end
        cout = c;
    end

    // Restore or keep the difference.
    always_comb begin
        q_bit_c  = cout;
        r_next_c = cout ? diff : t[WIDTH-1:0];
    end

endmodule

// File: rtl/isp_seq_divider.sv
// Iterative restoring divider: quotient = (dividend << SHIFT) / divisor,
// saturated to WIDTH bits, one operation in flight, valid/ready both sides.
module isp_seq_divider
    import isp_seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             saturated
);

    localparam int unsigned NI    = n_iter(WIDTH, SHIFT);
    localparam int unsigned CNT_W = cnt_width(NI);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] dvs_q;
    logic [NI-1:0]    n_q;
    logic [NI-1:0]    acc_q;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept_c;
    logic             dvz_c;
    logic             finish_c;
    logic             q_bit_c;
    logic [WIDTH-1:0] r_nx_c;
    logic [NI-1:0]    acc_nx_c;
    logic             sat_c;

    isp_seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in     (r_q),
        .n_msb    (n_q[NI-1]),
        .divisor  (dvs_q),
        .r_next_c (r_nx_c),
        .q_bit_c  (q_bit_c)
    );

    assign acc_nx_c = {acc_q[NI-2:0], q_bit_c};
    assign sat_c    = |acc_nx_c[NI-1:WIDTH];
    assign dvz_c    = (dvs_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a zero divisor skips the iteration after one BUSY cycle.
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        finish_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (dvz_c || (cnt_q == CNT_W'(1))) begin
                    finish_c = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, handshake and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            saturated   <= 1'b0;
            dvs_q       <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);

            if (accept_c) begin
                dvs_q <= divisor;
                n_q   <= NI'(dividend) << SHIFT;
                acc_q <= '0;
                r_q   <= '0;
                cnt_q <= CNT_W'(NI);
            end else if ((state == BUSY) && !dvz_c) begin
                n_q   <= {n_q[NI-2:0], 1'b0};
                acc_q <= acc_nx_c;
                r_q   <= r_nx_c;
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (finish_c) begin
                if (dvz_c) begin
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= 1'b1;
                    saturated   <= 1'b0;
                end else begin
                    quotient    <= sat_c ? '1 : acc_nx_c[WIDTH-1:0];
                    remainder   <= r_nx_c;
                    div_by_zero <= 1'b0;
                    saturated   <= sat_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_isp_seq_divider.sv
// Scoreboard bench for isp_seq_divider at default parameters.
module tb_isp_seq_divider;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned SHIFT = 8;

    typedef struct {
        int q;
        int r;
        int dbz;
        int sat;
        int lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             saturated;

    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    isp_seq_divider #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .saturated   (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t model(input int dvd, input int dvs);
        exp_t e;
        int   full;
        if (dvs == 0) begin
            e.q = 4095; e.r = 0; e.dbz = 1; e.sat = 0; e.lat = 1;
        end else begin
            full  = (dvd * 256) / dvs;
            e.r   = (dvd * 256) % dvs;
            e.sat = (full >= 4096) ? 1 : 0;
            e.q   = e.sat ? 4095 : full;
            e.dbz = 0;
            e.lat = 20;
        end
        return e;
    endfunction

    // Issue one operation, optionally stall the result, then retire it.
    task automatic run_op(input int dvd, input int dvs, input int hold);
        exp_t e;
        int   lat;
        int   waited;
        sb.push_back(model(dvd, dvs));
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        dividend = WIDTH'(dvd);
        divisor  = WIDTH'(dvs);
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Junk request held during BUSY must be ignored.
        dividend = '1;
        divisor  = 12'd1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'(e.q));
            check("hold_remainder", 32'(remainder), 32'(e.r));
        end
        in_valid  = 1'b0;
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("saturated", 32'(saturated), 32'(e.sat));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_by_zero, saturated}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1000, 512, 0);
        run_op(7, 100, 0);
        run_op(4095, 4095, 0);
        run_op(1000, 3, 0);
        run_op(0, 1, 0);
        run_op(55, 0, 0);
        run_op(100, 7, 5);
        for (int k = 0; k < 6; k++) begin
            run_op(int'($urandom_range(0, 4095)), int'($urandom_range(1, 4095)), k % 2);
        end

        // Abort during BUSY step 10.
        dividend = 12'd1000;
        divisor  = 12'd512;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_flags", 32'({div_by_zero, saturated}), 32'd0);
        run_op(1000, 512, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/isp_seq_divider.md
Name: isp_seq_divider

Overview:
- Iterative radix-2 restoring divider for the ISP datapath.
- Computes quotient = (dividend << SHIFT) / divisor. This is the inverse of the existing multiply-then-right-shift gain path, used for normalisation and for deriving gain from ratios.
- One division in flight at a time.
- valid/ready on input and output; result saturates to WIDTH bits, matching the pixel clamp range.

Parameters:
- WIDTH, 12, bit width of dividend, divisor, quotient and remainder.
- SHIFT, 8, fractional bits prepended to the dividend (fixed-point scale).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  WIDTH  unsigned numerator before scaling.
- divisor  input  WIDTH  unsigned denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- quotient  output  WIDTH  saturated quotient.
- remainder  output  WIDTH  true remainder of the full-width division.
- div_by_zero  output  1  divisor was 0.
- saturated  output  1  full quotient was at least 2^WIDTH and has been clamped.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset: state IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero and saturated are all 0. Reset mid-operation aborts the operation with no result produced.
- Constant N_ITER = WIDTH+SHIFT (20 at defaults).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On accept (in_valid && in_ready):
    - latch divisor;
    - load shift register n = {dividend, SHIFT zeros} (WIDTH+SHIFT bits);
    - clear partial remainder r (WIDTH+1 bits);
    - load counter with N_ITER.
  - If the latched divisor is 0, go to DONE on the next edge: quotient = all ones, remainder=0, div_by_zero=1, saturated=0.
  - Otherwise go to BUSY.
- BUSY: one restoring step per clock.
  - t = {r[WIDTH-1:0], n MSB}; shift n left by 1.
  - If t >= divisor: r = t - divisor and shift 1 into the quotient accumulator.
  - Otherwise: r = t and shift 0 into the quotient accumulator.
  - Subtraction is done as t + ~divisor + 1. Carry-out = 1 means no borrow, i.e. t >= divisor.
  - Counter decrements each step; when it reaches 0, go to DONE.
- Latency:
  - out_valid rises exactly N_ITER edges after the accepting edge (20 at defaults).
  - Divide-by-zero: out_valid rises 1 edge after the accepting edge.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient = accumulator if accumulator < 2^WIDTH; otherwise 2^WIDTH-1 with saturated=1.
  - remainder = r[WIDTH-1:0].
  - All outputs are registered and held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE. out_valid falls and in_ready rises on the following cycle; there is no same-cycle re-accept.
  - Maximum throughput is one operation per N_ITER+2 cycles.
- Inputs are ignored outside IDLE. in_valid during BUSY or DONE has no effect.
- After leaving DONE, result outputs keep their last values until the next DONE. They are only meaningful while out_valid=1.
- Widths:
  - accumulator is WIDTH+SHIFT bits;
  - saturation test is accumulator[WIDTH+SHIFT-1:WIDTH] != 0;
  - remainder is always < divisor, so it fits in WIDTH bits.

Decomposition:
- Shared ISP package holds:
  - FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - N_ITER derivation;
  - counter width $clog2(N_ITER+1).
- One natural sub-module, div_step: combinational single restoring step.
  - Builds the subtractor from the existing rca with inverter on divisor and cin=1.
  - Outputs the next remainder and the quotient bit.
- FSM, counter, shift registers and output registers live in isp_seq_divider.

Test Plan:
1. dividend=1000, divisor=512 -> quotient=500, remainder=0, saturated=0, div_by_zero=0; out_valid exactly 20 cycles after accept.
2. dividend=7, divisor=100 (1792/100) -> quotient=17, remainder=92; then dividend=4095, divisor=4095 -> quotient=256, remainder=0.
3. dividend=1000, divisor=3 (256000/3=85333 r 1) -> quotient=4095, saturated=1, remainder=1. Then dividend=0, divisor=1 -> quotient=0, remainder=0.
4. divisor=0, dividend=55 -> out_valid 1 cycle after accept; quotient=4095, remainder=0, div_by_zero=1, saturated=0.
5. Backpressure:
   - hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, extra in_valid pulses ignored;
   - raise out_ready -> handshake, in_ready=1 the next cycle.
6. Reset mid-operation:
   - assert rst_n=0 for one edge during BUSY step 10 -> out_valid=0, all result outputs 0, in_ready=1 immediately after;
   - a subsequent 1000/512 returns 500 with no stale-state corruption.
